// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage.
// Holds opcode/funct encodings, the ALU operation encoding, the default
// bubble instruction word and the ID/EX control bundle.
package id_pkg;

    localparam int NUM_REGS = 32;

    localparam logic [31:0] BUBBLE_IR_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_SLT    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_LUI    = 4'd7,
        ALU_PASS_B = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
    } idex_ctrl_t;

    localparam idex_ctrl_t CTRL_NOP = '{
        valid:     1'b0,
        alu_op:    ALU_ADD,
        alu_src:   1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        reg_write: 1'b0
    };

endpackage

// File: rtl/id_seg_reg_file.sv
// 32x32 register file: two combinational read ports, one write port.
// Ports: clk, rst (sync, active-low clear), addr_a/addr_b -> data_a/data_b,
//        we/wr_addr/wr_data write port.
// $0 always reads zero; a read of the address being written this cycle
// returns the write data so write-back results are visible to decode.
module reg_file
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr_a,
    input  logic [4:0]  addr_b,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] regs [NUM_REGS];
    logic        wr_en;

    assign wr_en = we && (wr_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        data_a = regs[addr_a];
        if (addr_a == 5'd0) begin
            data_a = '0;
        end else if (wr_en && (wr_addr == addr_a)) begin
            data_a = wr_data;
        end
    end

    always_comb begin
        data_b = regs[addr_b];
        if (addr_b == 5'd0) begin
            data_b = '0;
        end else if (wr_en && (wr_addr == addr_b)) begin
            data_b = wr_data;
        end
    end

endmodule

// File: rtl/id_seg.sv
// Instruction-decode stage: IF/ID register, R/I/J decode, register read,
// branch/jump resolution, hazard detection and the ID/EX register.
// Ports: clk, rst (sync, active-low); IRi/PCi from fetch; EX/MEM destination
// info for hazards; wbWe/wbAddr/wbData register write; stall/cond/condNPC
// back to fetch; idex* registered operands and control to EX.
module id_seg
    import id_pkg::*;
#(
    parameter logic [31:0] BUBBLE_IR = BUBBLE_IR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IRi,
    input  logic [31:0] PCi,
    input  logic        exRegWrite,
    input  logic        exMemRead,
    input  logic [4:0]  exRd,
    input  logic        memRegWrite,
    input  logic [4:0]  memRd,
    input  logic        wbWe,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    output logic        stall,
    output logic        cond,
    output logic [31:0] condNPC,
    output logic [31:0] idexPC,
    output logic [31:0] idexA,
    output logic [31:0] idexB,
    output logic [31:0] idexImm,
    output logic [4:0]  idexRs,
    output logic [4:0]  idexRt,
    output logic [4:0]  idexRd,
    output logic [3:0]  idexAluOp,
    output logic        idexAluSrc,
    output logic        idexMemRead,
    output logic        idexMemWrite,
    output logic        idexRegWrite,
    output logic        idexValid
);
    logic [31:0] ifid_ir, ifid_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, zext_imm, pc4, br_tgt, j_tgt, target;
    logic [31:0] rs_val, rt_val;
    idex_ctrl_t  ctrl;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        uses_rs, uses_rt, is_br, is_bne, is_jr, is_jmp, is_jal;
    logic        taken, redirect, load_use, rs_pending, rt_pending, src_hazard;

    assign opcode   = ifid_ir[31:26];
    assign rs       = ifid_ir[25:21];
    assign rt       = ifid_ir[20:16];
    assign rd       = ifid_ir[15:11];
    assign shamt    = ifid_ir[10:6];
    assign funct    = ifid_ir[5:0];
    assign sext_imm = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
    assign zext_imm = {16'h0, ifid_ir[15:0]};
    assign pc4      = ifid_pc + 32'd4;
    assign br_tgt   = pc4 + (sext_imm << 2);
    assign j_tgt    = {pc4[31:28], ifid_ir[25:0], 2'b00};

    reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .addr_a  (rs),
        .addr_b  (rt),
        .data_a  (rs_val),
        .data_b  (rt_val),
        .we      (wbWe),
        .wr_addr (wbAddr),
        .wr_data (wbData)
    );

    always_comb begin
        ctrl    = CTRL_NOP;
        imm     = '0;
        dest    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_br   = 1'b0;
        is_bne  = 1'b0;
        is_jr   = 1'b0;
        is_jmp  = 1'b0;
        is_jal  = 1'b0;
        if (ifid_ir != BUBBLE_IR) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                            ctrl.valid     = 1'b1;
                            ctrl.reg_write = 1'b1;
                            dest           = rd;
                            uses_rs        = 1'b1;
                            uses_rt        = 1'b1;
                            case (funct)
                                FN_SUB:  ctrl.alu_op = ALU_SUB;
                                FN_AND:  ctrl.alu_op = ALU_AND;
                                FN_OR:   ctrl.alu_op = ALU_OR;
                                FN_SLT:  ctrl.alu_op = ALU_SLT;
                                default: ctrl.alu_op = ALU_ADD;
                            endcase
                        end
                        FN_SLL, FN_SRL: begin
                            ctrl.valid     = 1'b1;
                            ctrl.reg_write = 1'b1;
                            ctrl.alu_op    = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                            dest           = rd;
                            uses_rt        = 1'b1;
                            imm            = {27'h0, shamt};
                        end
                        FN_JR: begin
                            ctrl.valid = 1'b1;
                            dest       = rd;
                            uses_rs    = 1'b1;
                            is_jr      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                    ctrl.valid     = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    dest           = rt;
                    uses_rs        = (opcode != OP_LUI);
                    case (opcode)
                        OP_ANDI: begin ctrl.alu_op = ALU_AND; imm = zext_imm; end
                        OP_ORI:  begin ctrl.alu_op = ALU_OR;  imm = zext_imm; end
                        OP_LUI:  begin ctrl.alu_op = ALU_LUI; imm = {ifid_ir[15:0], 16'h0}; end
                        default: begin ctrl.alu_op = ALU_ADD; imm = sext_imm; end
                    endcase
                    ctrl.mem_read = (opcode == OP_LW);
                end
                OP_SW: begin
                    ctrl.valid     = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    dest           = rt;
                    imm            = sext_imm;
                    uses_rs        = 1'b1;
                    uses_rt        = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    ctrl.valid  = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                    dest        = rt;
                    imm         = sext_imm;
                    uses_rs     = 1'b1;
                    uses_rt     = 1'b1;
                    is_br       = 1'b1;
                    is_bne      = (opcode == OP_BNE);
                end
                OP_J, OP_JAL: begin
                    ctrl.valid = 1'b1;
                    is_jmp     = 1'b1;
                    if (opcode == OP_JAL) begin
                        is_jal         = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.alu_op    = ALU_PASS_B;
                        dest           = 5'd31;
                    end
                end
                default: ;
            endcase
        end
    end

    // A register is "pending" when an older in-flight instruction will write it
    // but its value cannot reach the ID-stage comparator yet.
    always_comb begin
        rs_pending = (rs != 5'd0) && ((exRegWrite && exRd == rs) || (memRegWrite && memRd == rs));
        rt_pending = (rt != 5'd0) && ((exRegWrite && exRd == rt) || (memRegWrite && memRd == rt));
        load_use   = exMemRead && (exRd != 5'd0) &&
                     ((uses_rs && exRd == rs) || (uses_rt && exRd == rt));
        src_hazard = (is_br && (rs_pending || rt_pending)) || (is_jr && rs_pending);
        stall      = ctrl.valid && (load_use || src_hazard);

        taken      = is_br && ((rs_val == rt_val) != is_bne);
        redirect   = taken || is_jmp || is_jr;
        target     = is_jr ? rs_val : (is_jmp ? j_tgt : br_tgt);
        cond       = redirect && !stall;
        condNPC    = cond ? target : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ifid_ir <= BUBBLE_IR;
            ifid_pc <= '0;
        end else if (!stall) begin
            ifid_ir <= cond ? BUBBLE_IR : IRi;
            ifid_pc <= PCi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || stall || !ctrl.valid) begin
            idexPC       <= '0;
            idexA        <= '0;
            idexB        <= '0;
            idexImm      <= '0;
            idexRs       <= '0;
            idexRt       <= '0;
            idexRd       <= '0;
            idexAluOp    <= '0;
            idexAluSrc   <= 1'b0;
            idexMemRead  <= 1'b0;
            idexMemWrite <= 1'b0;
            idexRegWrite <= 1'b0;
            idexValid    <= 1'b0;
        end else begin
            idexPC       <= ifid_pc;
            idexA        <= rs_val;
            idexB        <= is_jal ? pc4 : rt_val;
            idexImm      <= imm;
            idexRs       <= rs;
            idexRt       <= rt;
            idexRd       <= dest;
            idexAluOp    <= ctrl.alu_op;
            idexAluSrc   <= ctrl.alu_src;
            idexMemRead  <= ctrl.mem_read;
            idexMemWrite <= ctrl.mem_write;
            idexRegWrite <= ctrl.reg_write;
            idexValid    <= 1'b1;
        end
    end

endmodule
